// File: rtl/crc_sector_feeder.sv
// Byte-stream feeder in front of the CRC engine: forwards one sector, waits for the engine's
// result (or a timeout) and hands one result record downstream. Optional macro: CRC_CHECK_EN.
module crc_sector_feeder #(
    parameter int SECTOR_BYTES = 512,
    parameter int TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  byte_out,
    output logic        wrreq,
    input  logic        buffer_full,
    input  logic        crc_done,
    input  logic [15:0] crc_value,
    output logic [15:0] res_crc,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_timeout,
    output logic        res_err,
    output logic        busy
);

    localparam int CW = $clog2(SECTOR_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(SECTOR_BYTES - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

`ifdef CRC_CHECK_EN
    typedef enum logic [1:0] {S_DATA, S_CHK, S_WAIT, S_RESULT} state_t;
`else
    typedef enum logic [1:0] {S_DATA, S_WAIT, S_RESULT} state_t;
`endif

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_next;
    logic [15:0]     r_res_crc;
    logic [15:0]     w_res_crc_next;
    logic            r_res_valid;
    logic            w_res_valid_next;
    logic            r_res_timeout;
    logic            w_res_timeout_next;
    logic            w_in_ready;
    logic            w_wrreq;

`ifdef CRC_CHECK_EN
    logic [15:0]     r_stored;
    logic [15:0]     w_stored_next;
    logic            r_chk_idx;
    logic            w_chk_idx_next;
    logic            r_res_err;
    logic            w_res_err_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_DATA;
            r_count       <= '0;
            r_timer       <= '0;
            r_res_crc     <= '0;
            r_res_valid   <= 1'b0;
            r_res_timeout <= 1'b0;
`ifdef CRC_CHECK_EN
            r_stored      <= '0;
            r_chk_idx     <= 1'b0;
            r_res_err     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_timer       <= w_timer_next;
            r_res_crc     <= w_res_crc_next;
            r_res_valid   <= w_res_valid_next;
            r_res_timeout <= w_res_timeout_next;
`ifdef CRC_CHECK_EN
            r_stored      <= w_stored_next;
            r_chk_idx     <= w_chk_idx_next;
            r_res_err     <= w_res_err_next;
`endif
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_count_next       = r_count;
        w_timer_next       = r_timer;
        w_res_crc_next     = r_res_crc;
        w_res_valid_next   = r_res_valid;
        w_res_timeout_next = r_res_timeout;
        w_in_ready         = 1'b0;
        w_wrreq            = 1'b0;
`ifdef CRC_CHECK_EN
        w_stored_next      = r_stored;
        w_chk_idx_next     = r_chk_idx;
        w_res_err_next     = r_res_err;
`endif
        case (r_state)
            S_DATA: begin
                w_in_ready = !buffer_full;
                w_wrreq    = in_valid && !buffer_full;
                if (w_wrreq) begin
                    if (r_count == LAST_BYTE) begin
                        w_count_next = '0;
`ifdef CRC_CHECK_EN
                        w_state_next = S_CHK;
`else
                        w_state_next = S_WAIT;
`endif
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end
            end
`ifdef CRC_CHECK_EN
            // Stored CRC arrives MSB first; it is consumed here and never reaches the engine.
            S_CHK: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_stored_next  = {r_stored[7:0], in_data};
                    w_chk_idx_next = !r_chk_idx;
                    if (r_chk_idx) begin
                        w_state_next = S_WAIT;
                    end
                end
            end
`endif
            S_WAIT: begin
                w_timer_next = r_timer + 1'b1;
                if (crc_done) begin
                    w_res_crc_next     = crc_value;
                    w_res_timeout_next = 1'b0;
                    w_res_valid_next   = 1'b1;
                    w_timer_next       = '0;
                    w_state_next       = S_RESULT;
`ifdef CRC_CHECK_EN
                    w_res_err_next     = (crc_value != r_stored);
`endif
                end else if (r_timer == LAST_TICK) begin
                    w_res_crc_next     = '0;
                    w_res_timeout_next = 1'b1;
                    w_res_valid_next   = 1'b1;
                    w_timer_next       = '0;
                    w_state_next       = S_RESULT;
`ifdef CRC_CHECK_EN
                    w_res_err_next     = 1'b1;
`endif
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    w_res_valid_next = 1'b0;
                    w_timer_next     = '0;
                    w_state_next     = S_DATA;
                end
            end
            default: begin
                w_state_next = S_DATA;
            end
        endcase
    end

    assign in_ready    = w_in_ready;
    assign wrreq       = w_wrreq;
    assign byte_out    = in_data;
    assign res_crc     = r_res_crc;
    assign res_valid   = r_res_valid;
    assign res_timeout = r_res_timeout;
    assign busy        = (r_state != S_DATA) || (r_count != '0);
`ifdef CRC_CHECK_EN
    assign res_err     = r_res_err;
`else
    assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_crc_sector_feeder.sv
// Bench for crc_sector_feeder (SECTOR_BYTES=4, TIMEOUT=16): table vectors, reset sequence and
// randomized sectors checked against a sector-level expectation model.
module tb_crc_sector_feeder;

    localparam int SB = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  byte_out;
    logic        wrreq;
    logic        buffer_full;
    logic        crc_done;
    logic [15:0] crc_value;
    logic [15:0] res_crc;
    logic        res_valid;
    logic        res_ready;
    logic        res_timeout;
    logic        res_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    crc_sector_feeder #(.SECTOR_BYTES(SB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .byte_out(byte_out), .wrreq(wrreq), .buffer_full(buffer_full),
        .crc_done(crc_done), .crc_value(crc_value),
        .res_crc(res_crc), .res_valid(res_valid), .res_ready(res_ready),
        .res_timeout(res_timeout), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] iv_mask;
        logic [31:0] bf_mask;
        int          done_dly;
        logic [15:0] crc_val;
        logic [15:0] stored;
        int          hold;
        logic [15:0] exp_crc;
        logic        exp_to;
        logic        exp_err;
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] data, input logic [31:0] iv, input logic [31:0] bf,
                                input int dly, input logic [15:0] cv, input logic [15:0] st,
                                input int hold, input logic [15:0] ec, input logic et, input logic ee);
        vec_t v;
        v.data = data; v.iv_mask = iv; v.bf_mask = bf; v.done_dly = dly;
        v.crc_val = cv; v.stored = st; v.hold = hold;
        v.exp_crc = ec; v.exp_to = et; v.exp_err = ee;
        return v;
    endfunction

    // Sector-level outcome: the engine result if crc_done arrives within the timeout window.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_to  = (v.done_dly >= TO);
        r.exp_crc = r.exp_to ? 16'h0000 : v.crc_val;
        r.exp_err = r.exp_to ? 1'b1 : (v.crc_val != v.stored);
        return r;
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = 8'h00; buffer_full = 1'b0;
        crc_done = 1'b0; crc_value = 16'h0000; res_ready = 1'b0;
    endtask

    task automatic run_sector(input vec_t v, input int id);
        int c = 0;
        int idx = 0;
        int wend;
        logic exp_wr;
        logic [7:0] b;
        logic exp_err;
        // Data phase: byte order and handshake against the bench's own offer pointer.
        while (idx < SB && c < 64) begin
            in_valid    = (c < 32) ? v.iv_mask[c] : 1'b1;
            buffer_full = (c < 32) ? v.bf_mask[c] : 1'b0;
            b           = v.data[8*idx +: 8];
            in_data     = in_valid ? b : 8'h5A;
            crc_done    = (c % 2) == 1;
            crc_value   = 16'hBAD0;
            #1;
            exp_wr = in_valid && !buffer_full;
            chk1("data_in_ready", in_ready, !buffer_full);
            chk1("data_wrreq", wrreq, exp_wr);
            if (exp_wr) begin
                chk16("data_byte_out", {8'h00, byte_out}, {8'h00, b});
                idx++;
            end
            @(posedge clk); #1;
            c++;
        end
        if (idx < SB) chk16("data_feed_bound", 16'(idx), 16'(SB));
`ifdef CRC_CHECK_EN
        for (int k = 0; k < 2; k++) begin
            in_valid    = 1'b1;
            buffer_full = 1'b1;
            in_data     = (k == 0) ? v.stored[15:8] : v.stored[7:0];
            crc_done    = 1'b0;
            #1;
            chk1("chk_in_ready", in_ready, 1'b1);
            chk1("chk_wrreq", wrreq, 1'b0);
            @(posedge clk); #1;
        end
        buffer_full = 1'b0;
`endif
        wend = (v.done_dly < TO) ? v.done_dly : TO - 1;
        for (int w = 0; w <= wend; w++) begin
            in_valid  = 1'b1;
            in_data   = 8'hEE;
            crc_done  = (w == v.done_dly);
            crc_value = (w == v.done_dly) ? v.crc_val : 16'h0BAD;
            #1;
            chk1("wait_res_valid", res_valid, 1'b0);
            chk1("wait_in_ready", in_ready, 1'b0);
            chk1("wait_wrreq", wrreq, 1'b0);
            chk1("wait_busy", busy, 1'b1);
            @(posedge clk); #1;
        end
`ifdef CRC_CHECK_EN
        exp_err = v.exp_err;
`else
        exp_err = 1'b0;
`endif
        // Result phase: held stable while res_ready is low; stray crc_done is ignored.
        for (int h = 0; h <= v.hold; h++) begin
            res_ready = (h == v.hold);
            crc_done  = 1'b1;
            crc_value = 16'h5555;
            #1;
            chk1("res_valid", res_valid, 1'b1);
            chk16("res_crc", res_crc, v.exp_crc);
            chk1("res_timeout", res_timeout, v.exp_to);
            chk1("res_err", res_err, exp_err);
            chk1("res_in_ready", in_ready, 1'b0);
            chk1("res_wrreq", wrreq, 1'b0);
            @(posedge clk); #1;
        end
        idle_inputs();
        #1;
        chk1("post_res_valid", res_valid, 1'b0);
        chk1("post_in_ready", in_ready, 1'b1);
        chk1("post_busy", busy, 1'b0);
        $display("sector %0d data=%h dly=%0d crc=%h to=%b err=%b", id, v.data, v.done_dly,
                 res_crc, res_timeout, res_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        vec_t rv;

        tbl[0] = mk(32'h00000000, 32'hFFFFFFFF, 32'h00000000,    3, 16'h1D0F, 16'h1D0F, 0, 16'h1D0F, 1'b0, 1'b0);
        tbl[1] = mk(32'h44332211, 32'hFFFFFFFF, 32'h0000001C,    0, 16'hA5A5, 16'hA5A4, 1, 16'hA5A5, 1'b0, 1'b1);
        tbl[2] = mk(32'hDEADBEEF, 32'hFFFFFFFA, 32'h00000000,    5, 16'h1234, 16'h1234, 5, 16'h1234, 1'b0, 1'b0);
        tbl[3] = mk(32'h01020304, 32'hFFFFFFFF, 32'h00000000, 1000, 16'h7777, 16'h7777, 2, 16'h0000, 1'b1, 1'b1);
        tbl[4] = mk(32'hCAFEF00D, 32'hFFFFFFFF, 32'h00000005,   15, 16'hBEEF, 16'hBEEF, 0, 16'hBEEF, 1'b0, 1'b0);
        tbl[5] = mk(32'h80402010, 32'hFFFFFFF5, 32'h00000022,   16, 16'h4321, 16'h4321, 1, 16'h0000, 1'b1, 1'b1);
        tbl[6] = mk(32'h00000000, 32'hFFFFFFFF, 32'h00000000,    2, 16'h1D0F, 16'h1D0E, 0, 16'h1D0F, 1'b0, 1'b1);

        idle_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        buffer_full = 1'b1;
        #1;
        chk1("rst_in_ready_bf1", in_ready, 1'b0);
        buffer_full = 1'b0;
        in_valid    = 1'b0;
        #1;
        chk1("rst_in_ready_bf0", in_ready, 1'b1);
        chk1("rst_res_valid", res_valid, 1'b0);
        chk16("rst_res_crc", res_crc, 16'h0000);
        chk1("rst_res_timeout", res_timeout, 1'b0);
        chk1("rst_res_err", res_err, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;

        for (int i = 0; i < 7; i++) run_sector(tbl[i], i);

        // Reset after two bytes: partial sector is dropped and counting restarts.
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(k);
            #1;
            chk1("prerst_wrreq", wrreq, 1'b1);
            @(posedge clk); #1;
        end
        chk1("prerst_busy", busy, 1'b1);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk1("midrst_res_valid", res_valid, 1'b0);
        chk16("midrst_res_crc", res_crc, 16'h0000);
        chk1("midrst_res_timeout", res_timeout, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_wrreq", wrreq, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        run_sector(mk(32'h0D0C0B0A, 32'hFFFFFFFF, 32'h00000000, 1, 16'h9999, 16'h9999, 0,
                      16'h9999, 1'b0, 1'b0), 100);

        for (int i = 0; i < 20; i++) begin
            rv.data     = $urandom;
            rv.iv_mask  = $urandom | $urandom;
            rv.bf_mask  = $urandom & $urandom;
            rv.done_dly = int'($urandom_range(0, 20));
            rv.crc_val  = 16'($urandom);
            rv.stored   = ($urandom_range(0, 1) == 1) ? rv.crc_val : 16'($urandom);
            rv.hold     = int'($urandom_range(0, 3));
            rv = model(rv);
            run_sector(rv, 200 + i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
